countdown_sequencer: RTL and testbench

COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

---
 rtl/countdown_pkg.sv | 14 +
 rtl/countdown_watchdog.sv | 28 ++
 rtl/countdown_sequencer.sv | 102 ++++++++++
 tb/tb_countdown_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown sequencer and its watchdog.
package countdown_pkg;
   localparam int CNT_W_DEF   = 5;
   localparam int TIMEOUT_DEF = 40;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      LAUNCH,
      ARMED,
      RUN,
      DONE
   } state_t;
endpackage

// File: rtl/countdown_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th one, so a ready return on that very cycle still wins.
module countdown_watchdog
   import countdown_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != WD_W'(TIMEOUT))
         cnt <= cnt + WD_W'(1);
   end

   assign expired = en && (cnt == WD_W'(TIMEOUT - 1));
endmodule

// File: rtl/countdown_sequencer.sv
// Runs cmd_reps countdowns on an external 31->0 counter, checking every step
// of the count and aborting through a watchdog if the counter never returns.
module countdown_sequencer
   import countdown_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [3:0]       cmd_reps,
   output logic             cmd_ready,
   output logic             start,
   input  logic             ready,
   input  logic [CNT_W-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       reps_left
);
   state_t           state, state_nxt;
   logic [CNT_W-1:0] prev_q, prev_q_nxt;
   logic [3:0]       reps_nxt;
   logic             err_nxt;
   logic             wd_clr, wd_en, wd_expired;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign start     = (state == LAUNCH);
   assign done      = (state == DONE);
   assign wd_clr    = (state == LAUNCH);
   assign wd_en     = (state == ARMED) || (state == RUN);

   countdown_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         prev_q    <= '0;
         err       <= 1'b0;
         reps_left <= '0;
      end else begin
         state     <= state_nxt;
         prev_q    <= prev_q_nxt;
         err       <= err_nxt;
         reps_left <= reps_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      prev_q_nxt = prev_q;
      err_nxt    = err;
      reps_nxt   = reps_left;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               reps_nxt  = cmd_reps;
               err_nxt   = 1'b0;
               state_nxt = (cmd_reps == 4'd0) ? DONE : ISSUE;
            end
         end
         ISSUE:  if (ready) state_nxt = LAUNCH;
         LAUNCH: state_nxt = ARMED;
         ARMED: begin
            if (!ready) begin
               prev_q_nxt = q;
               state_nxt  = RUN;
            end else if (wd_expired) begin
               err_nxt   = 1'b1;
               reps_nxt  = '0;
               state_nxt = DONE;
            end
         end
         RUN: begin
            prev_q_nxt = q;
            // Completion is tested first so a return on the expiry cycle is clean.
            if (ready) begin
               reps_nxt  = reps_left - 4'd1;
               state_nxt = (reps_left == 4'd1) ? DONE : ISSUE;
            end else begin
               if (q != prev_q - CNT_W'(1))
                  err_nxt = 1'b1;
               if (wd_expired) begin
                  err_nxt   = 1'b1;
                  reps_nxt  = '0;
                  state_nxt = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench: behavioural counter with per-start latency/skip settings, and a
// timeline model that predicts start/done/reps_left cycles per command.
module tb_countdown_sequencer;
   localparam int TIMEOUT = 40;

   logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
   logic [3:0] cmd_reps = 4'd0;
   logic       cmd_ready, start, ready, busy, done, err;
   logic [4:0] q;
   logic [3:0] reps_left;

   int total = 0, bad = 0, cyc = 0;

   // counter model configuration, indexed by start number
   int lat_cfg[64];
   bit skip_cfg[64];
   int nstart = 0, k = 0, cur_lat = 32;
   bit cur_skip = 1'b0, act = 1'b0;

   countdown_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_reps(cmd_reps),
      .cmd_ready(cmd_ready), .start(start), .ready(ready), .q(q),
      .busy(busy), .done(done), .err(err), .reps_left(reps_left)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [4:0] qval(input int kk, input bit sk);
      int v;
      v = (sk && kk > 12) ? 31 - kk : 32 - kk;
      return v[4:0];
   endfunction

   // Counter: start loads 31, ready low for cur_lat-1 cycles, then idle at 0.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         act <= 1'b0;
      end else if (start && !act) begin
         act      <= 1'b1;
         k        <= 1;
         cur_lat  <= lat_cfg[nstart % 64];
         cur_skip <= skip_cfg[nstart % 64];
         nstart   <= nstart + 1;
      end else if (act) begin
         if (k >= cur_lat - 1) act <= 1'b0;
         else k <= k + 1;
      end
   end
   assign ready = !act;
   assign q     = act ? qval(k, cur_skip) : 5'd0;

   task automatic set_cfg(input int i, input int lat, input bit sk);
      lat_cfg[(nstart + i) % 64]  = lat;
      skip_cfg[(nstart + i) % 64] = sk;
   endtask

   // Waits for an idle block and counter, then presents one command.
   task automatic issue(input int r, output bit ok, output int a);
      int n = 0;
      @(negedge clk);
      while (!(cmd_ready === 1'b1 && ready === 1'b1) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      ok        = (n < 2000);
      a         = cyc;
      cmd_valid = 1'b1;
      cmd_reps  = 4'(r);
   endtask

   task automatic run_cmd(input int r, input bit noise);
      int base, a, s, d_exp, lat, exp_rl;
      int exp_start[$], rl_cyc[$], rl_val[$];
      bit ok, err_exp, exp_st;
      int st_mm = 0, dn_mm = 0, bz_mm = 0, rl_mm = 0, viol = 0, er_mm = 0, clr_mm = 0;
      int st_at = -1, rl_at = -1, rl_got = 0, rl_exp = 0;
      base = nstart;
      issue(r, ok, a);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL cmd_wait: block never idle, cmd_ready=%b ready=%b required 1/1", cmd_ready, ready);
      end
      err_exp = 1'b0;
      s       = a + 2;
      d_exp   = a + 1;
      rl_cyc.push_back(a + 1);
      rl_val.push_back(r);
      for (int i = 0; i < r; i++) begin
         lat = lat_cfg[(base + i) % 64];
         exp_start.push_back(s);
         if (lat > TIMEOUT) begin
            err_exp = 1'b1;
            d_exp   = s + TIMEOUT + 1;
            rl_cyc.push_back(d_exp);
            rl_val.push_back(0);
            break;
         end
         if (skip_cfg[(base + i) % 64]) err_exp = 1'b1;
         rl_cyc.push_back(s + lat + 1);
         rl_val.push_back(r - i - 1);
         d_exp = s + lat + 1;
         s     = s + lat + 2;
      end
      for (int c = a + 1; c <= d_exp + 2; c++) begin
         @(negedge clk);
         exp_st = 1'b0;
         foreach (exp_start[j]) if (exp_start[j] == c) exp_st = 1'b1;
         exp_rl = 0;
         foreach (rl_cyc[j]) if (rl_cyc[j] <= c) exp_rl = rl_val[j];
         if (start !== exp_st) begin
            if (st_mm == 0) st_at = c - a;
            st_mm++;
         end
         if (start === 1'b1 && ready !== 1'b1) viol++;
         if (done !== (c == d_exp)) dn_mm++;
         if (busy !== (c <= d_exp) || cmd_ready !== (c > d_exp)) bz_mm++;
         if (reps_left !== 4'(exp_rl)) begin
            if (rl_mm == 0) begin rl_at = c - a; rl_got = reps_left; rl_exp = exp_rl; end
            rl_mm++;
         end
         if (c >= d_exp && err !== err_exp) er_mm++;
         if (c == a + 1 && err !== 1'b0) clr_mm++;
         if (noise && c < d_exp) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_reps  = 4'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
      end
      total++;
      if (st_mm != 0) begin bad++; $display("FAIL start_trace reps=%0d: %0d wrong cycles, first at +%0d, required 0", r, st_mm, st_at); end
      total++;
      if (viol != 0) begin bad++; $display("FAIL start_while_busy reps=%0d: %0d starts with ready=0, required 0", r, viol); end
      total++;
      if (dn_mm != 0) begin bad++; $display("FAIL done_trace reps=%0d: %0d wrong cycles, required done only at +%0d", r, dn_mm, d_exp - a); end
      total++;
      if (bz_mm != 0) begin bad++; $display("FAIL busy_trace reps=%0d: %0d wrong cycles, required 0", r, bz_mm); end
      total++;
      if (rl_mm != 0) begin bad++; $display("FAIL reps_left reps=%0d: got %0d at +%0d, required %0d", r, rl_got, rl_at, rl_exp); end
      total++;
      if (er_mm != 0) begin bad++; $display("FAIL err_at_done reps=%0d: %0d wrong cycles, required err=%0b", r, er_mm, err_exp); end
      total++;
      if (clr_mm != 0) begin bad++; $display("FAIL err_clear reps=%0d: err still 1 after accept, required 0", r); end
   endtask

   task automatic test_reset;
      #1 rst = 1'b0;
      #1;
      total++;
      if ({cmd_ready, start, busy, done, err, reps_left} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
         bad++;
         $display("FAIL reset_state: rdy/st/busy/done/err/reps=%b%b%b%b%b/%0d required 10000/0",
                  cmd_ready, start, busy, done, err, reps_left);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
      end
   endtask

   task automatic test_single;
      set_cfg(0, 32, 1'b0);
      run_cmd(1, 1'b0);
   endtask

   task automatic test_multi;
      for (int i = 0; i < 3; i++) set_cfg(i, 32, 1'b0);
      run_cmd(3, 1'b0);
   endtask

   task automatic test_zero;
      run_cmd(0, 1'b0);
   endtask

   task automatic test_skip;
      int held = 0;
      set_cfg(0, 31, 1'b1);
      run_cmd(1, 1'b0);
      repeat (5) begin
         @(negedge clk);
         if (err !== 1'b1) held++;
      end
      total++;
      if (held != 0) begin bad++; $display("FAIL err_sticky: err dropped on %0d idle cycles, required 0", held); end
      set_cfg(0, 32, 1'b0);
      run_cmd(1, 1'b0);
   endtask

   task automatic test_timeout;
      set_cfg(0, 1000, 1'b0);
      run_cmd(3, 1'b0);
   endtask

   task automatic test_boundary;
      set_cfg(0, TIMEOUT, 1'b0);
      set_cfg(1, TIMEOUT + 1, 1'b0);
      run_cmd(2, 1'b0);
      set_cfg(0, TIMEOUT, 1'b0);
      run_cmd(1, 1'b0);
   endtask

   task automatic test_random;
      int r, sel;
      for (int t = 0; t < 10; t++) begin
         r = $urandom_range(0, 4);
         for (int i = 0; i < r; i++) begin
            sel = $urandom_range(0, 9);
            set_cfg(i, (sel == 0) ? TIMEOUT + 1 + $urandom_range(0, 4) : $urandom_range(25, TIMEOUT),
                    ($urandom_range(0, 3) == 0));
         end
         run_cmd(r, 1'b1);
      end
   endtask

   task automatic test_reset_mid_run;
      bit ok;
      int a, n, dn = 0;
      for (int i = 0; i < 3; i++) set_cfg(i, 32, 1'b0);
      issue(3, ok, a);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (20) @(negedge clk);
      total++;
      if (!ok || busy !== 1'b1 || ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_run_setup: ok=%b busy=%b ready=%b required 1/1/0", ok, busy, ready);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({start, busy, cmd_ready, done, reps_left} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
         bad++;
         $display("FAIL mid_run_reset: st/busy/rdy/done/reps=%b%b%b%b/%0d required 0010/0",
                  start, busy, cmd_ready, done, reps_left);
      end
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) dn++;
      end
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_reps  = 4'd0;
      @(negedge clk);
      total++;
      if (dn != 0 || done !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL accept_after_release: stray=%0d done=%b busy=%b required 0/1/1", dn, done, busy);
      end
      cmd_valid = 1'b0;
      // second reset lands exactly on the start pulse
      for (int i = 0; i < 2; i++) set_cfg(i, 32, 1'b0);
      issue(2, ok, a);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (start !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b0;
      #1;
      total++;
      if (n >= 10 || start !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL launch_reset: waited=%0d start=%b busy=%b required <10/0/0", n, start, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      dn  = 0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) dn++;
      end
      total++;
      if (dn != 0) begin bad++; $display("FAIL no_done_after_reset: %0d done cycles, required 0", dn); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         lat_cfg[i]  = 32;
         skip_cfg[i] = 1'b0;
      end
      test_reset;
      test_single;
      test_multi;
      test_zero;
      test_skip;
      test_timeout;
      test_boundary;
      test_random;
      test_reset_mid_run;
      test_single;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: bench did not finish, required finish");
      $fatal(1);
   end
endmodule
